divider_8_arbiter: RTL
======================

Name: divider_8_arbiter

Overview:
Hardware controller that shares a single repetitive-subtraction divider datapath between two requesters, for example the PicoBlaze output port and the switch/button channel. It arbitrates round-robin, captures the winner's operands and sequences the subtraction loop. It then holds the result in a Done state until the owning requester acknowledges. It exposes the same Qi/Qc/Qd state indication used by the software divider, so board LEDs and SSD logic can attach unchanged.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits

Ports:
Clk  input  1  system clock (board_clk domain)
Resetn  input  1  asynchronous, active-low reset
Start0  input  1  requester 0 start (level)
Xin0  input  WIDTH  requester 0 dividend
Yin0  input  WIDTH  requester 0 divisor
Ack0  input  1  requester 0 result acknowledge
Start1  input  1  requester 1 start (level)
Xin1  input  WIDTH  requester 1 dividend
Yin1  input  WIDTH  requester 1 divisor
Ack1  input  1  requester 1 result acknowledge
Grant  output  2  one-hot current owner; 00 when idle
Done0  output  1  result valid for requester 0
Done1  output  1  result valid for requester 1
Quotient  output  WIDTH  quotient; valid while Done0/Done1 is high
Remainder  output  WIDTH  remainder; valid while Done0/Done1 is high
DivByZero  output  1  current result came from Y=0
Busy  output  1  high in COMPUTE or DONE
Qi, Qc, Qd  output  1 each  one-hot state indicators

Behaviour:
- One clock: Clk. Reset is asynchronous and active-low: Resetn.
- Reset values, applied asynchronously on Resetn=0, including mid-operation:
  - state INITIAL
  - Qi=1, Qc=0, Qd=0
  - Grant=00, Done0=Done1=0
  - Quotient=0, Remainder=0, DivByZero=0, Busy=0
  - internal last_served=1, so requester 0 wins the first tie.
- States: INITIAL (Qi), COMPUTE (Qc), DONE (Qd). Exactly one Q flag is high.
- INITIAL arbitration:
  - Only Start0 high -> grant 0. Only Start1 high -> grant 1.
  - Both high -> grant the requester != last_served.
  - Neither high -> stay in INITIAL.
- On grant, in the same edge:
  - Grant <= one-hot(owner).
  - Internal X <= Xin_owner, Y <= Yin_owner.
  - Quotient <= 0, DivByZero <= 0.
  - Operands are sampled once; later input changes are ignored.
- Divide by zero: if Yin_owner == 0 at grant, go directly to DONE.
  - DivByZero <= 1, Quotient <= all ones, Remainder <= Xin_owner.
  - COMPUTE is skipped.
- COMPUTE, each cycle:
  - If X >= Y (unsigned): X <= X - Y, Quotient <= Quotient + 1.
  - Else: Remainder <= X, go to DONE.
  - Cycles spent in COMPUTE = Q + 1. Maximum is 2^WIDTH (X=255, Y=1).
  - No overflow is possible, since Q <= X.
- DONE:
  - Done_owner = 1. The other Done stays 0.
  - Quotient and Remainder are held stable.
  - Ack_owner = 1 -> INITIAL next edge; last_served <= owner; Grant <= 00; Done cleared.
  - Ack from the non-owner is ignored. Start inputs are ignored.
- After DONE, Quotient, Remainder and DivByZero hold their values until the next grant.
- A requester still holding Start on return to INITIAL may be re-granted, subject to round-robin if the other requester is also requesting.
- Busy = Qc | Qd.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
1. Single requester: Resetn pulse, then Start0=1, X0=13, Y0=4.
   -> Grant=01, Qc for 4 cycles, then Qd and Done0=1, Quotient=3, Remainder=1.
   -> Ack0 -> Qi next edge, Grant=00.
2. Tie after reset: Start0=Start1=1 in the same cycle, X0=200/Y0=10, X1=7/Y1=9.
   -> Requester 0 served first: Q=20, R=0.
   -> After Ack0, requester 1 is granted: Q=0, R=7, with exactly 1 Qc cycle.
   -> With both still requesting, the next grant goes back to requester 0.
3. Divide by zero: Start1, X1=5, Y1=0.
   -> Qc never asserted; DONE one cycle after grant.
   -> DivByZero=1, Quotient=FF, Remainder=05, Done1=1.
4. Worst case: X0=255, Y0=1.
   -> Exactly 256 cycles in Qc, then Quotient=FF, Remainder=00, DivByZero=0.
5. Handshake isolation: owner 0 in DONE, assert Ack1 and Start1 for 5 cycles.
   -> State stays DONE, Done0 stays 1, outputs unchanged.
   -> Ack0 then returns to INITIAL and grants requester 1 next.
6. Reset mid-operation: drop Resetn during COMPUTE (X0=100, Y0=3).
   -> Outputs go to reset values immediately (Qi=1, Grant=00, Quotient=0).
   -> After release, a fresh Start0 yields Q=33, R=1.

Source files
------------

// File: rtl/divider_8_arbiter.sv
// divider_8_arbiter
//   Shares one repetitive-subtraction divider between two requesters.
//   In INITIAL the block arbitrates round-robin between Start0 and Start1.
//   It captures the winner's operands, then subtracts once per cycle in
//   COMPUTE. The result is held in DONE until the owner acknowledges.
//
// Ports
//   Clk, Resetn        clock, asynchronous active-low reset
//   Start0/1           level start request per requester
//   Xin0/1, Yin0/1     dividend / divisor per requester (sampled at grant)
//   Ack0/1             result acknowledge per requester (owner's only)
//   Grant              one-hot current owner, 00 when idle
//   Done0/1            result valid for the owning requester
//   Quotient/Remainder result, held from DONE until the next grant
//   DivByZero          current result came from a zero divisor
//   Busy               COMPUTE or DONE
//   Qi/Qc/Qd           one-hot state indicators
module divider_8_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Start0,
    input  logic [WIDTH-1:0] Xin0,
    input  logic [WIDTH-1:0] Yin0,
    input  logic             Ack0,
    input  logic             Start1,
    input  logic [WIDTH-1:0] Xin1,
    input  logic [WIDTH-1:0] Yin1,
    input  logic             Ack1,
    output logic [1:0]       Grant,
    output logic             Done0,
    output logic             Done1,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero,
    output logic             Busy,
    output logic             Qi,
    output logic             Qc,
    output logic             Qd
);

    typedef enum logic [1:0] {
        INITIAL,
        COMPUTE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic             last_served;
    logic             any_start;
    logic             pick_one;
    logic [WIDTH-1:0] xin_sel;
    logic [WIDTH-1:0] yin_sel;
    logic             ack_owner;

    // Requester 1 wins when it is the only one asking, or on a tie when
    // requester 0 was the last one served.
    always_comb begin
        any_start = Start0 | Start1;
        pick_one  = Start1 & (~Start0 | ~last_served);
        xin_sel   = pick_one ? Xin1 : Xin0;
        yin_sel   = pick_one ? Yin1 : Yin0;
        ack_owner = (Grant[0] & Ack0) | (Grant[1] & Ack1);
    end

    // State register
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state <= INITIAL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            INITIAL: begin
                if (any_start) begin
                    state_next = (yin_sel == '0) ? DONE : COMPUTE;
                end
            end
            COMPUTE: begin
                if (x_reg < y_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (ack_owner) begin
                    state_next = INITIAL;
                end
            end
            default: state_next = INITIAL;
        endcase
    end

    // Datapath and ownership registers
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            Grant       <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            DivByZero   <= 1'b0;
            last_served <= 1'b1;
        end else begin
            case (state)
                INITIAL: begin
                    if (any_start) begin
                        Grant <= pick_one ? 2'b10 : 2'b01;
                        x_reg <= xin_sel;
                        y_reg <= yin_sel;
                        if (yin_sel == '0) begin
                            Quotient  <= '1;
                            Remainder <= xin_sel;
                            DivByZero <= 1'b1;
                        end else begin
                            Quotient  <= '0;
                            DivByZero <= 1'b0;
                        end
                    end
                end
                COMPUTE: begin
                    if (x_reg >= y_reg) begin
                        x_reg    <= x_reg - y_reg;
                        Quotient <= Quotient + WIDTH'(1);
                    end else begin
                        Remainder <= x_reg;
                    end
                end
                DONE: begin
                    if (ack_owner) begin
                        last_served <= Grant[1];
                        Grant       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        Qi    = (state == INITIAL);
        Qc    = (state == COMPUTE);
        Qd    = (state == DONE);
        Busy  = (state == COMPUTE) | (state == DONE);
        Done0 = (state == DONE) & Grant[0];
        Done1 = (state == DONE) & Grant[1];
    end

endmodule
